// File: rtl/stack_pkg.sv
// Shared definitions for the return stack: operation encoding and count-width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  // The count must represent 0..depth inclusive, hence one bit more than the address.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/stack_ptr_next.sv
// Combinational next-count / write-address logic for the return stack.
module stack_ptr_next
  import stack_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic [PTR_W-1:0] i_count,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_clear,
  input  logic             i_empty,
  input  logic             i_full,
  output logic [PTR_W-1:0] o_count_next,
  output logic             o_wr_en,
  output logic [PTR_W-2:0] o_wr_addr,
  output logic             o_overflow_pulse,
  output logic             o_underflow_pulse
);

  localparam int AW = PTR_W - 1;

  stack_op_e        w_op;
  logic [PTR_W-1:0] w_count_inc;
  logic [PTR_W-1:0] w_count_dec;

  assign w_count_inc = i_count + 1'b1;
  assign w_count_dec = i_count - 1'b1;

  // A replace on an empty stack has no top to overwrite, so it degrades to a push.
  always_comb begin
    w_op = stack_op_e'({i_push, i_pop});
    if (w_op == OP_REPLACE && i_empty) begin
      w_op = OP_PUSH;
    end
  end

  always_comb begin
    o_count_next      = i_count;
    o_wr_en           = 1'b0;
    o_wr_addr         = i_count[AW-1:0];
    o_overflow_pulse  = 1'b0;
    o_underflow_pulse = 1'b0;
    if (i_clear) begin
      o_count_next = '0;
    end else begin
      case (w_op)
        OP_PUSH: begin
          if (i_full) begin
            o_overflow_pulse = 1'b1;
          end else begin
            o_wr_en      = 1'b1;
            o_wr_addr    = i_count[AW-1:0];
            o_count_next = w_count_inc;
          end
        end
        OP_POP: begin
          if (i_empty) begin
            o_underflow_pulse = 1'b1;
          end else begin
            o_count_next = w_count_dec;
          end
        end
        OP_REPLACE: begin
          o_wr_en   = 1'b1;
          o_wr_addr = w_count_dec[AW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/return_stack.sv
// LIFO return stack with combinational top-of-stack read and sticky error flags.
module return_stack
  import stack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int PTR_W  = ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] top,
  output logic [PTR_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = PTR_W - 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic [PTR_W-1:0]  w_count_next;
  logic              w_wr_en;
  logic [AW-1:0]     w_wr_addr;
  logic              w_overflow_pulse;
  logic              w_underflow_pulse;
  logic [PTR_W-1:0]  w_top_ptr;

  assign empty = (r_count == '0);
  assign full  = (r_count == PTR_W'(DEPTH));

  stack_ptr_next #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ptr_next (
    .i_count           (r_count),
    .i_push            (push),
    .i_pop             (pop),
    .i_clear           (clear),
    .i_empty           (empty),
    .i_full            (full),
    .o_count_next      (w_count_next),
    .o_wr_en           (w_wr_en),
    .o_wr_addr         (w_wr_addr),
    .o_overflow_pulse  (w_overflow_pulse),
    .o_underflow_pulse (w_underflow_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count <= w_count_next;
      if (w_overflow_pulse) begin
        r_overflow <= 1'b1;
      end
      if (w_underflow_pulse) begin
        r_underflow <= 1'b1;
      end
    end
  end

  // Storage is never reset; a write coinciding with reset is dropped with the rest of the op.
  always_ff @(posedge clk) begin
    if (!reset && w_wr_en) begin
      r_mem[w_wr_addr] <= din;
    end
  end

  assign w_top_ptr = r_count - 1'b1;
  assign top       = empty ? '0 : r_mem[w_top_ptr[AW-1:0]];
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_return_stack.sv
// Directed scoreboard bench for return_stack at DATA_W=8, DEPTH=4.
module tb_return_stack;

  logic       clk = 1'b0;
  logic       reset, push, pop, clear;
  logic [7:0] din;
  logic [7:0] top;
  logic [2:0] count;
  logic       empty, full, overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    int         cnt;
    logic [7:0] top;
    bit         empty;
    bit         full;
    bit         ovf;
    bit         udf;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  return_stack #(
    .DATA_W (8),
    .DEPTH  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .din       (din),
    .top       (top),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string nm, input string field, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, field, act, req);
    end
  endtask

  // Drive one cycle of stimulus and record what the stack must show after the edge.
  task automatic op(input string nm, input bit rs, input bit ps, input bit pp, input bit cl,
                    input logic [7:0] d, input int ec, input logic [7:0] et,
                    input bit ee, input bit ef, input bit eo, input bit eu);
    exp_t e;
    @(negedge clk);
    reset = rs; push = ps; pop = pp; clear = cl; din = d;
    e.name = nm; e.cnt = ec; e.top = et;
    e.empty = ee; e.full = ef; e.ovf = eo; e.udf = eu;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "count", int'(count), e.cnt);
        chk(e.name, "top", int'(top), int'(e.top));
        chk(e.name, "empty", int'(empty), int'(e.empty));
        chk(e.name, "full", int'(full), int'(e.full));
        chk(e.name, "overflow", int'(overflow), int'(e.ovf));
        chk(e.name, "underflow", int'(underflow), int'(e.udf));
        $display("txn %-14s count=%0d top=0x%02h empty=%0b full=%0b ovf=%0b udf=%0b",
                 e.name, count, top, empty, full, overflow, underflow);
      end
    end
  end

  initial begin : driver
    reset = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; din = 8'h00;
    //   name            rs ps pp cl din    cnt top    e  f  o  u
    op("reset",          1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    op("push11",         0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 0);
    op("push22",         0, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 0);
    op("push33",         0, 1, 0, 0, 8'h33, 3, 8'h33, 0, 0, 0, 0);
    op("push44",         0, 1, 0, 0, 8'h44, 4, 8'h44, 0, 1, 0, 0);
    op("push55_ovf",     0, 1, 0, 0, 8'h55, 4, 8'h44, 0, 1, 1, 0);
    op("pop1",           0, 0, 1, 0, 8'h00, 3, 8'h33, 0, 0, 1, 0);
    op("pop2",           0, 0, 1, 0, 8'h00, 2, 8'h22, 0, 0, 1, 0);
    op("pop3",           0, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0, 1, 0);
    op("pop4",           0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 0);
    op("pop5_udf",       0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 1, 1);
    op("reset2",         1, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    op("push11b",        0, 1, 0, 0, 8'h11, 1, 8'h11, 0, 0, 0, 0);
    op("push22b",        0, 1, 0, 0, 8'h22, 2, 8'h22, 0, 0, 0, 0);
    op("replaceAA",      0, 1, 1, 0, 8'hAA, 2, 8'hAA, 0, 0, 0, 0);
    op("popAA",          0, 0, 1, 0, 8'h00, 1, 8'h11, 0, 0, 0, 0);
    op("pop11",          0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    op("pop_udf",        0, 0, 1, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1);
    op("pushpop_emptyBB",0, 1, 1, 0, 8'hBB, 1, 8'hBB, 0, 0, 0, 1);
    op("push88",         0, 1, 0, 0, 8'h88, 2, 8'h88, 0, 0, 0, 1);
    op("push99",         0, 1, 0, 0, 8'h99, 3, 8'h99, 0, 0, 0, 1);
    op("push66",         0, 1, 0, 0, 8'h66, 4, 8'h66, 0, 1, 0, 1);
    op("push55_ovf2",    0, 1, 0, 0, 8'h55, 4, 8'h66, 0, 1, 1, 1);
    op("pop_to3",        0, 0, 1, 0, 8'h00, 3, 8'h99, 0, 0, 1, 1);
    op("clear_push",     0, 1, 0, 1, 8'hEE, 0, 8'h00, 1, 0, 1, 1);
    op("push77",         0, 1, 0, 0, 8'h77, 1, 8'h77, 0, 0, 1, 1);
    op("nop_hold",       0, 0, 0, 0, 8'h5A, 1, 8'h77, 0, 0, 1, 1);
    op("push12",         0, 1, 0, 0, 8'h12, 2, 8'h12, 0, 0, 1, 1);
    op("reset_in_push",  1, 1, 0, 0, 8'h34, 0, 8'h00, 1, 0, 0, 0);
    op("push56",         0, 1, 0, 0, 8'h56, 1, 8'h56, 0, 0, 0, 0);
    op("clear_pop",      0, 0, 1, 1, 8'h00, 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/return_stack.md
RETURN_STACK -- requirements
Module: return_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of each stack entry.
REQ-002 SHALL have parameter DEPTH, default 32: number of entries; power of two, minimum 2.
REQ-003 SHALL have derived parameter PTR_W = clog2(DEPTH) + 1: width of the entry count, so the range 0..DEPTH is representable.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port push, input, 1 bit: write din onto the stack this cycle.
REQ-007 SHALL have port pop, input, 1 bit: remove the top entry this cycle.
REQ-008 SHALL have port clear, input, 1 bit: synchronous flush of all entries, without clearing the error flags.
REQ-009 SHALL have port din, input, DATA_W bits: data pushed.
REQ-010 SHALL have port top, output, DATA_W bits: current top-of-stack entry; all zeros when empty.
REQ-011 SHALL have port count, output, PTR_W bits: number of valid entries.
REQ-012 SHALL have ports empty and full, output, 1 bit each: count==0 and count==DEPTH respectively.
REQ-013 SHALL have ports overflow and underflow, output, 1 bit each: sticky error flags.

Function
REQ-014 SHALL hold entries in an array mem[0..DEPTH-1]; count is the stack pointer, and the top entry is mem[count-1].
REQ-015 SHALL read top combinationally from the current count and mem; a push or pop becomes visible on top in the cycle after its edge.
REQ-016 SHALL, on push only with not full: write din to mem[count] and increment count by 1.
REQ-017 SHALL, on pop only with not empty: decrement count by 1; mem contents are unchanged.
REQ-018 SHALL, on push and pop together with not empty: write din to mem[count-1] (replace top) and leave count unchanged.
REQ-019 SHALL, on push and pop together with empty: act as push only; underflow is not set.
REQ-020 SHALL, on push only with full: leave count and mem unchanged and set overflow.
REQ-021 SHALL, on pop only with empty: leave count unchanged and set underflow.
REQ-022 SHALL keep count within 0..DEPTH at all times; no modular wrap-around is permitted.
REQ-023 SHALL, when clear is high: set count to 0 next cycle, overriding push and pop; overflow and underflow hold their values.
REQ-024 SHALL keep overflow and underflow set until reset.
REQ-025 SHALL, with neither push nor pop asserted: hold all state.

Reset
REQ-026 SHALL, when reset is high at a clock edge: set count=0, overflow=0 and underflow=0; top therefore reads 0, empty=1 and full=0.
REQ-027 SHALL give reset priority over clear, push and pop; a reset mid-operation discards the in-flight operation.
REQ-028 SHALL NOT reset mem contents; they are unobservable while empty.

Structure
REQ-029 SHALL place the stack-operation encoding (NOP, PUSH, POP, REPLACE) and the helper computing PTR_W in a shared package, stack_pkg.
REQ-030 SHALL isolate next-count and write-address computation in one combinational sub-module, stack_ptr_next. It takes count, push, pop, clear, empty and full, and outputs next count, write enable, write address, and overflow/underflow pulses.
REQ-031 SHALL keep mem and the flag registers in return_stack.

Verification (DATA_W=8, DEPTH=4)
REQ-032 SHALL cover: reset -> count=0, empty=1, top=0x00, both flags 0.
REQ-033 SHALL cover: push 0x11, 0x22, 0x33, 0x44 -> count=4, full=1, top=0x44; then push 0x55 -> count=4, top=0x44, overflow=1.
REQ-034 SHALL cover: from full, pop four times -> top sequence 0x33, 0x22, 0x11, 0x00, empty=1; a fifth pop -> underflow=1, count=0.
REQ-035 SHALL cover: with count=2 and top=0x22, push and pop with din=0xAA -> count=2, top=0xAA; the same stimulus with empty and din=0xBB -> count=1, top=0xBB, underflow unchanged.
REQ-036 SHALL cover: count=3, then clear and push asserted together -> count=0, overflow unchanged; next cycle push 0x77 -> top=0x77.
REQ-037 SHALL cover: reset asserted during push with count=2 -> count=0 next cycle, flags cleared.
